vx_fetch_ibuf: RTL

Per-issue-slice instruction buffer directly downstream of the fetch stage. Accepts I-cache fetch responses (PC, tmask, wid, instr, uuid), queues them in one FIFO per issue slice, and drains them to decode via round-robin arbitration. Each drained entry raises `ibuf_pop[slice]`, which returns credit to fetch's per-slice pending counters, so the buffer never overflows in normal operation.

---
 rtl/vx_fetch_ibuf_if.sv | 26 ++
 rtl/vx_fetch_ibuf.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vx_fetch_ibuf_if.sv
// Handshake bundle carrying one instruction-fetch response.
// The master drives valid and the payload; the slave drives ready.
interface vx_fetch_ibuf_if #(
  parameter int NW_WIDTH   = 4,
  parameter int XLEN       = 32,
  parameter int THREAD_CNT = 4,
  parameter int UUID_WIDTH = 44
);
  logic                  valid;
  logic                  ready;
  logic [NW_WIDTH-1:0]   wid;
  logic [XLEN-1:0]       PC;
  logic [THREAD_CNT-1:0] tmask;
  logic [31:0]           instr;
  logic [UUID_WIDTH-1:0] uuid;

  modport master (
    output valid, wid, PC, tmask, instr, uuid,
    input  ready
  );

  modport slave (
    input  valid, wid, PC, tmask, instr, uuid,
    output ready
  );
endinterface

// File: rtl/vx_fetch_ibuf.sv
// Per-issue-slice instruction buffer between fetch and decode.
// Each slice owns a FIFO; a round-robin arbiter drains the heads to decode
// and every drained entry pulses ibuf_pop[slice] to return a fetch credit.
module vx_fetch_ibuf #(
  parameter int ISSUE_CNT  = 4,
  parameter int WARP_CNT   = 16,
  parameter int THREAD_CNT = 4,
  parameter int DEPTH      = 4,
  parameter int XLEN       = 32,
  parameter int UUID_WIDTH = 44,
  parameter int NW_WIDTH   = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_fetch_ibuf_if.slave        in_if,
  vx_fetch_ibuf_if.master       out_if,
  output logic [ISSUE_CNT-1:0]  ibuf_pop
);

  localparam int ISW_W = (ISSUE_CNT > 1) ? $clog2(ISSUE_CNT) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = NW_WIDTH + XLEN + THREAD_CNT + 32 + UUID_WIDTH;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Slice that owns a warp: warps are striped across slices modulo ISSUE_CNT.
  function automatic logic [ISW_W-1:0] wid_to_isw(input logic [NW_WIDTH-1:0] wid);
    return ISW_W'(32'(wid) % 32'(ISSUE_CNT));
  endfunction

  // Slice index base+off with wrap-around at ISSUE_CNT.
  function automatic logic [ISW_W-1:0] slice_add(input logic [ISW_W-1:0] base,
                                                 input int unsigned      off);
    return ISW_W'((32'(base) + off) % 32'(ISSUE_CNT));
  endfunction

  // Storage is payload only; it carries no reset.
  logic [ENT_W-1:0] mem [ISSUE_CNT][DEPTH];

  logic [PTR_W-1:0] rptr [ISSUE_CNT];
  logic [PTR_W-1:0] wptr [ISSUE_CNT];
  logic [PTR_W:0]   cnt  [ISSUE_CNT];
  logic [ISW_W-1:0] rr_ptr;

  logic [ISSUE_CNT-1:0] empty;
  logic [ISSUE_CNT-1:0] full;
  logic [ISSUE_CNT-1:0] push_sel;
  logic [ISW_W-1:0]     push_isw;
  logic                 push;
  logic [ISW_W-1:0]     grant;
  logic                 found;
  logic                 fire;
  logic [ENT_W-1:0]     in_entry;
  logic [ENT_W-1:0]     head;

  // Per-slice occupancy flags decoded from the registered counts.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < ISSUE_CNT; i++) begin
      empty[i] = (cnt[i] == '0);
      full[i]  = (cnt[i] == FULL_CNT);
    end
  end

  // Push side: ready depends only on the target slice's registered fullness,
  // so a slice that pops this cycle still refuses a push while full.
  assign push_isw     = wid_to_isw(in_if.wid);
  assign in_if.ready  = ~full[push_isw];
  assign push         = in_if.valid & in_if.ready;
  assign in_entry     = {in_if.wid, in_if.PC, in_if.tmask, in_if.instr, in_if.uuid};

  // One-hot push select per slice.
  always_comb begin
    push_sel = '0;
    if (push) push_sel[push_isw] = 1'b1;
  end

  // Round-robin grant: first non-empty slice starting at rr_ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < ISSUE_CNT; i++) begin
      if (!found && !empty[slice_add(rr_ptr, i)]) begin
        grant = slice_add(rr_ptr, i);
        found = 1'b1;
      end
    end
  end

  // Output side: head of the granted slice, valid whenever any slice holds data.
  assign head            = mem[grant][rptr[grant]];
  assign out_if.valid    = found;
  assign {out_if.wid, out_if.PC, out_if.tmask, out_if.instr, out_if.uuid} = head;
  assign fire            = found & out_if.ready;

  // Credit return pulse in the same cycle as the decode handshake.
  always_comb begin
    ibuf_pop = '0;
    if (fire) ibuf_pop[grant] = 1'b1;
  end

  // Pointer, count and arbiter state; reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ISSUE_CNT; i++) begin
        rptr[i] <= '0;
        wptr[i] <= '0;
        cnt[i]  <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < ISSUE_CNT; i++) begin
        if (push_sel[i]) wptr[i] <= wptr[i] + 1'b1;
        if (ibuf_pop[i]) rptr[i] <= rptr[i] + 1'b1;
        case ({push_sel[i], ibuf_pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      // With a single slice slice_add always yields 0, so rr_ptr stays 0.
      if (fire) rr_ptr <= slice_add(grant, 1);
    end
  end

  // Payload write into the target slice at its write pointer.
  always_ff @(posedge clk) begin
    if (push) mem[push_isw][wptr[push_isw]] <= in_entry;
  end

  // Fetch's pending-credit counters must keep it from offering to a full slice.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(in_if.valid && !in_if.ready))
        else $error("vx_fetch_ibuf: credit-protocol violation, push offered to full slice");
    end
  end

endmodule
